// File: rtl/wu_fetch_sequencer_pkg.sv
// rtl/wu_fetch_sequencer_pkg.sv - shared types and defaults for the WU fetch sequencer
package wu_fetch_sequencer_pkg;

    localparam int WUF_ADDR_W  = 10;
    localparam int WUF_CREDITS = 4;
    localparam int WUF_MEM_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wuf_state_e;

    // One slot per outstanding read; live drops when the read becomes wrong-path.
    typedef struct packed {
        logic issued;
        logic live;
    } keep_ent_t;

endpackage

// File: rtl/wu_fetch_credit_counter.sv
// rtl/wu_fetch_credit_counter.sv - saturating decode-credit counter with sticky overflow flag
module wu_fetch_credit_counter #(
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic          inc_int_i,
    input  logic          inc_ext_i,
    output logic [CW-1:0] count_o,
    output logic          err_o
);

    localparam logic [CW:0] FULL = (CW + 1)'(CREDITS);

    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;
    logic [CW:0]   sum;
    logic          overflow;

    always_comb begin
        sum      = {1'b0, count_q} + {{CW{1'b0}}, inc_int_i} + {{CW{1'b0}}, inc_ext_i}
                 - {{CW{1'b0}}, dec_i};
        overflow = (sum > FULL);
        err_d    = err_q | overflow;
        if (load_i || overflow) begin
            count_d = FULL[CW-1:0];
        end else begin
            count_d = sum[CW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            count_q <= FULL[CW-1:0];
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/wu_fetch_sequencer.sv
// rtl/wu_fetch_sequencer.sv - credit-paced WU instruction fetch with keep/squash tagging
module wu_fetch_sequencer
    import wu_fetch_sequencer_pkg::*;
#(
    parameter int ADDR_W  = WUF_ADDR_W,
    parameter int CREDITS = WUF_CREDITS,
    parameter int MEM_LAT = WUF_MEM_LAT
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              sys__wuf__start,
    input  logic [ADDR_W-1:0] sys__wuf__start_addr,
    output logic              wuf__sys__busy,
    output logic              wuf__sys__done,
    output logic              wuf__sys__credit_err,
    output logic              wuf__wum__valid,
    output logic              wuf__wum__read,
    output logic [ADDR_W-1:0] wuf__wum__addr,
    output logic              wuf__wud__keep,
    input  logic              wud__wuf__credit,
    input  logic              wud__wuf__jump,
    input  logic [ADDR_W-1:0] wud__wuf__jump_addr,
    input  logic              wud__wuf__halt
);

    localparam int CW = $clog2(CREDITS + 1);

    wuf_state_e                 state_q, state_d;
    logic [ADDR_W-1:0]          pc_q, pc_d;
    keep_ent_t [MEM_LAT-1:0]    pipe_q, pipe_d;
    logic                       valid_q, valid_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [CW-1:0]              credits;
    logic                       issue, kill, load, drained, keep, ret_int;

    wu_fetch_credit_counter #(
        .CREDITS (CREDITS),
        .CW      (CW)
    ) u_credit (
        .clk       (clk),
        .rst_i     (reset_poweron),
        .load_i    (load),
        .dec_i     (issue),
        .inc_int_i (ret_int),
        .inc_ext_i (wud__wuf__credit),
        .count_o   (credits),
        .err_o     (wuf__sys__credit_err)
    );

    // The oldest slot exits this cycle, so only the younger slots hold reads still owed.
    always_comb begin
        drained = 1'b1;
        for (int i = 0; i < MEM_LAT - 1; i++) begin
            if (pipe_q[i].issued) drained = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        issue   = 1'b0;
        kill    = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // done_q high means we left DRAIN on the last edge; that start is dropped.
                if (sys__wuf__start && !done_q) begin
                    state_d = ST_RUN;
                    pc_d    = sys__wuf__start_addr;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                if (wud__wuf__halt) begin
                    state_d = ST_DRAIN;
                    kill    = 1'b1;
                end else if (wud__wuf__jump) begin
                    kill    = 1'b1;
                    pc_d    = wud__wuf__jump_addr;
                end else if (credits != '0) begin
                    issue   = 1'b1;
                    pc_d    = pc_q + ADDR_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    load    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A kill also squashes the word returning in the same cycle as the redirect.
        keep    = pipe_q[MEM_LAT-1].issued & pipe_q[MEM_LAT-1].live & ~kill;
        ret_int = pipe_q[MEM_LAT-1].issued & ~keep;

        pipe_d[0].issued = issue;
        pipe_d[0].live   = issue;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_d[i].issued = pipe_q[i-1].issued;
            pipe_d[i].live   = pipe_q[i-1].live & ~kill;
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            pipe_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pipe_q  <= pipe_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign wuf__sys__busy  = busy_q;
    assign wuf__sys__done  = done_q;
    assign wuf__wum__valid = valid_q;
    assign wuf__wum__read  = issue;
    assign wuf__wum__addr  = pc_q;
    assign wuf__wud__keep  = keep;

endmodule
